// File: rtl/onchip_arb_pkg.sv
// onchip_arb_pkg: shared types and defaults for the on-chip RAM arbiter.
// Optional build macro used by the arbiter: ONCHIP_ARB_PERF_EN.
package onchip_arb_pkg;

  localparam int ARB_ADDR_W   = 14;
  localparam int ARB_DATA_W   = 32;
  localparam int ARB_DEPTH    = 10000;
  localparam int ARB_LOCK_MAX = 16;

  // IDLE arbitrates round-robin; OWNn keeps the RAM with requester n
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  // Requester id: 0 = Nios II data master, 1 = DMA master
  typedef logic req_id_t;

  function automatic req_id_t other_port(input req_id_t id);
    return ~id;
  endfunction

endpackage

// File: rtl/onchip_mem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin picker. ptr names the port that wins a tie.
module rr_arb2
  import onchip_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    ptr,
  output logic [1:0] grant
);

  // A port wins when it is the only requester or when the pointer favours it
  always_comb begin
    grant    = 2'b00;
    grant[0] = req[0] & (~req[1] | (ptr == 1'b0));
    grant[1] = req[1] & (~req[0] | (ptr == 1'b1));
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter: shares one single-port RAM between the Nios II data
// master (port 0) and the DMA master (port 1). Round-robin in IDLE, bounded
// lock for read-modify-write, out-of-range accesses dropped and flagged.
// Build macro ONCHIP_ARB_PERF_EN adds saturating grant/stall counters.
module onchip_mem_arbiter
  import onchip_arb_pkg::*;
#(
  parameter int ADDR_W   = ARB_ADDR_W,
  parameter int DATA_W   = ARB_DATA_W,
  parameter int DEPTH    = ARB_DEPTH,
  parameter int LOCK_MAX = ARB_LOCK_MAX
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   r0_address,
  input  logic [DATA_W/8-1:0] r0_byteenable,
  input  logic                r0_read,
  input  logic                r0_write,
  input  logic [DATA_W-1:0]   r0_writedata,
  input  logic                r0_lock,
  output logic                r0_waitrequest,
  output logic [DATA_W-1:0]   r0_readdata,
  output logic                r0_readdatavalid,
  input  logic [ADDR_W-1:0]   r1_address,
  input  logic [DATA_W/8-1:0] r1_byteenable,
  input  logic                r1_read,
  input  logic                r1_write,
  input  logic [DATA_W-1:0]   r1_writedata,
  input  logic                r1_lock,
  output logic                r1_waitrequest,
  output logic [DATA_W-1:0]   r1_readdata,
  output logic                r1_readdatavalid,
  input  logic                freeze,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic                oor_err
`ifdef ONCHIP_ARB_PERF_EN
  ,
  output logic [31:0]         perf_grant0,
  output logic [31:0]         perf_grant1,
  output logic [31:0]         perf_stall0,
  output logic [31:0]         perf_stall1
`endif
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

  logic [1:0]        req;
  logic [1:0]        is_write;
  logic [1:0]        lock;
  logic [1:0]        rr_gnt;
  logic [1:0]        gnt;
  logic              any_gnt;
  req_id_t           win;
  logic              win_oor;
  logic              win_write;
  logic              win_lock;
  logic [ADDR_W-1:0] sel_address;

  arb_state_t        state_reg, state_next;
  req_id_t           rr_ptr_reg;
  logic [CNT_W-1:0]  lock_cnt_reg;
  logic              rd_valid_reg;
  req_id_t           rd_owner_reg;
  logic              rd_oor_reg;
  logic              oor_err_reg;

  assign req      = {r1_read | r1_write, r0_read | r0_write};
  assign is_write = {r1_write, r0_write};
  assign lock     = {r1_lock, r0_lock};

  rr_arb2 u_rr_arb2 (
    .req   (req),
    .ptr   (rr_ptr_reg),
    .grant (rr_gnt)
  );

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // FSM next state: enter OWNn on a locked grant, leave on lock drop or timeout
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (any_gnt && win_lock) state_next = win ? OWN1 : OWN0;
      OWN0: if (!freeze && (!r0_lock || lock_cnt_reg >= CNT_LAST)) state_next = IDLE;
      OWN1: if (!freeze && (!r1_lock || lock_cnt_reg >= CNT_LAST)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: grant vector; nothing is granted while frozen or in reset
  always_comb begin
    gnt = 2'b00;
    if (!freeze && !reset) begin
      case (state_reg)
        IDLE:    gnt = rr_gnt;
        OWN0:    gnt = {1'b0, req[0]};
        OWN1:    gnt = {req[1], 1'b0};
        default: gnt = 2'b00;
      endcase
    end
  end

  assign any_gnt   = |gnt;
  assign win       = gnt[1];
  assign win_write = is_write[win];
  assign win_lock  = lock[win];

  assign sel_address    = win ? r1_address : r0_address;
  assign win_oor        = 32'(sel_address) >= 32'(DEPTH);
  assign mem_address    = sel_address;
  assign mem_byteenable = win ? r1_byteenable : r0_byteenable;
  assign mem_writedata  = win ? r1_writedata : r0_writedata;
  assign mem_chipselect = any_gnt & ~win_oor;
  assign mem_write      = mem_chipselect & win_write;
  assign mem_clken      = 1'b1;

  assign r0_waitrequest = ~gnt[0];
  assign r1_waitrequest = ~gnt[1];
  assign oor_err        = oor_err_reg;

  // Lock counter: counts ownership cycles including the locking grant; holds while frozen
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   lock_cnt_reg <= '0;
    else if (state_next == IDLE) lock_cnt_reg <= '0;
    else if (state_reg == IDLE)  lock_cnt_reg <= CNT_W'(1);
    else if (!freeze)            lock_cnt_reg <= lock_cnt_reg + CNT_W'(1);
  end

  // Round-robin pointer: after any grant the other port wins the next tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        rr_ptr_reg <= 1'b0;
    else if (any_gnt) rr_ptr_reg <= other_port(win);
  end

  // Read-return pipeline: tag each granted read so its data goes back one cycle later
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid_reg <= 1'b0;
      rd_owner_reg <= 1'b0;
      rd_oor_reg   <= 1'b0;
    end else begin
      rd_valid_reg <= any_gnt & ~win_write;
      rd_owner_reg <= win;
      rd_oor_reg   <= win_oor;
    end
  end

  // Sticky out-of-range flag, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  oor_err_reg <= 1'b0;
    else if (any_gnt & win_oor) oor_err_reg <= 1'b1;
  end

  logic [1:0]        rdv;
  logic [DATA_W-1:0] rdata [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_ret
    assign rdv[gi]   = rd_valid_reg && (rd_owner_reg == 1'(gi));
    // Out-of-range reads return zero instead of the RAM's stale q output
    assign rdata[gi] = (rdv[gi] && !rd_oor_reg) ? mem_readdata : '0;
  end

  assign r0_readdatavalid = rdv[0];
  assign r1_readdatavalid = rdv[1];
  assign r0_readdata      = rdata[0];
  assign r1_readdata      = rdata[1];

`ifdef ONCHIP_ARB_PERF_EN
  logic [31:0] grant_cnt_reg [2];
  logic [31:0] stall_cnt_reg [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_perf
    // Saturating per-port counters of accepted accesses and stalled request cycles
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        grant_cnt_reg[gi] <= '0;
        stall_cnt_reg[gi] <= '0;
      end else begin
        if (gnt[gi] && grant_cnt_reg[gi] != '1)
          grant_cnt_reg[gi] <= grant_cnt_reg[gi] + 32'd1;
        if (req[gi] && !gnt[gi] && stall_cnt_reg[gi] != '1)
          stall_cnt_reg[gi] <= stall_cnt_reg[gi] + 32'd1;
      end
    end
  end

  assign perf_grant0 = grant_cnt_reg[0];
  assign perf_grant1 = grant_cnt_reg[1];
  assign perf_stall0 = stall_cnt_reg[0];
  assign perf_stall1 = stall_cnt_reg[1];
`endif

endmodule
